mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_resp_pkg.sv | 29 ++
 rtl/mem_resp_array.sv | 40 ++++
 rtl/mem_responder.sv | 138 +++++++++++++
 tb/tb_mem_responder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared widths, defaults, FSM state and op encodings for mem_responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_resp_pkg;

    localparam int ADDR_W          = 24;
    localparam int DATA_W          = 8;
    localparam int CNT_W           = 4;
    localparam int STAT_W          = 16;
    localparam int MEM_AW_DEFAULT  = 10;
    localparam int LATENCY_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    // Saturating increment for the completion counters.
    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/mem_resp_array.sv
// mem_resp_array: single-port byte RAM, synchronous write and synchronous read with read enable.
// Latency: write commits and read data registers on the edge where the enable is high.
// Backpressure: none; read data holds until the next read enable, contents survive reset.
module mem_resp_array
    import mem_resp_pkg::*;
#(
    parameter int MEM_AW = MEM_AW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [MEM_AW-1:0] addr_i,
    input  logic [DATA_W-1:0] wdat_i,
    output logic [DATA_W-1:0] rdat_o
);

    // Storage starts zeroed at power-up only; reset never touches it.
    logic [DATA_W-1:0] mem_q [0:(1<<MEM_AW)-1] = '{default: '0};
    logic [DATA_W-1:0] rdat_q;

    // Write port: commit on enable.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdat_i;
        end
    end

    // Read port: output register only updates on a read, so it holds across writes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdat_q <= '0;
        end else if (re_i) begin
            rdat_q <= mem_q[addr_i];
        end
    end

    assign rdat_o = rdat_q;

endmodule

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency byte memory responder; optional completion counters under MEM_RESP_STATS_EN.
// Latency: RDY rises LATENCY edges after the request is sampled, lasts one cycle; next sample at +LATENCY+2.
// Backpressure: none; processor holds read/write until RDY, input changes while busy are ignored.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int MEM_AW  = MEM_AW_DEFAULT,
    parameter int LATENCY = LATENCY_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_out,
    input  logic              read,
    input  logic              write,
    output logic [DATA_W-1:0] data_in,
    output logic              RDY,
    output logic [STAT_W-1:0] rd_count,
    output logic [STAT_W-1:0] wr_count
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rdy_q;
    logic              take;
    logic              done;
    logic [MEM_AW-1:0] addr_q;
    logic [DATA_W-1:0] wdat_q;
    op_e               op_q;
    logic              mem_we;
    logic              mem_re;

    // Upper address bits alias away by design.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[ADDR_W-1:MEM_AW];

    // Next-state: sample in IDLE, count down in WAIT, single-cycle RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (read || write) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    take    = 1'b1;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    done    = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, countdown and RDY registers; RDY is the registered decode of entering RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= (state_d == RESP);
        end
    end

    // Request capture; read wins when both read and write are asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            wdat_q <= '0;
            op_q   <= OP_READ;
        end else if (take) begin
            addr_q <= addr[MEM_AW-1:0];
            wdat_q <= data_out;
            op_q   <= read ? OP_READ : OP_WRITE;
        end
    end

    // Memory access happens only on the WAIT->RESP edge, so an aborted request never commits.
    assign mem_we = done && (op_q == OP_WRITE);
    assign mem_re = done && (op_q == OP_READ);

    mem_resp_array #(
        .MEM_AW (MEM_AW)
    ) u_array (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (mem_we),
        .re_i   (mem_re),
        .addr_i (addr_q),
        .wdat_i (wdat_q),
        .rdat_o (data_in)
    );

    assign RDY = rdy_q;

`ifdef MEM_RESP_STATS_EN
    logic [STAT_W-1:0] rd_cnt_q;
    logic [STAT_W-1:0] wr_cnt_q;

    // Completion counters bump on RESP entry and stick at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (mem_re) begin
                rd_cnt_q <= sat_inc(rd_cnt_q);
            end
            if (mem_we) begin
                wr_cnt_q <= sat_inc(wr_cnt_q);
            end
        end
    end

    assign rd_count = rd_cnt_q;
    assign wr_count = wr_cnt_q;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed bench for mem_responder at LATENCY 2, 1 and 15.
// Latency: checks RDY timing relative to the sampling edge and back-to-back spacing.
// Backpressure: requests are held until RDY and dropped on the following negedge.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] addr;
    logic [7:0]  data_out;
    logic        read, write;
    logic        read_a, read_b, write_ab;
    logic [7:0]  data_in, data_in_a, data_in_b;
    logic        rdy, rdy_a, rdy_b;
    logic [15:0] rd_count, wr_count, rd_count_a, wr_count_a, rd_count_b, wr_count_b;

    int vectors     = 0;
    int miscompares = 0;

`ifdef MEM_RESP_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    always #5 clk = ~clk;

    mem_responder u_dut (
        .clk (clk), .rst_n (rst_n), .addr (addr), .data_out (data_out),
        .read (read), .write (write), .data_in (data_in), .RDY (rdy),
        .rd_count (rd_count), .wr_count (wr_count)
    );

    mem_responder #(.LATENCY(1)) u_l1 (
        .clk (clk), .rst_n (rst_n), .addr (addr), .data_out (data_out),
        .read (read_a), .write (write_ab), .data_in (data_in_a), .RDY (rdy_a),
        .rd_count (rd_count_a), .wr_count (wr_count_a)
    );

    mem_responder #(.LATENCY(15)) u_l15 (
        .clk (clk), .rst_n (rst_n), .addr (addr), .data_out (data_out),
        .read (read_b), .write (write_ab), .data_in (data_in_b), .RDY (rdy_b),
        .rd_count (rd_count_b), .wr_count (wr_count_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait through the sampling edge, then count edges until RDY (bounded).
    task automatic await_rdy(output int lat, output logic [7:0] dq);
        lat = 99;
        dq  = 8'hEE;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (rdy) begin
                lat = k;
                dq  = data_in;
                break;
            end
        end
    endtask

    // One request on the LATENCY=2 instance: latency, RDY width and returned data.
    task automatic txn(input string tag, input logic rd, input logic wr,
                       input logic [23:0] a, input logic [7:0] d, output logic [7:0] dq);
        int lat;
        @(negedge clk);
        addr = a; data_out = d; read = rd; write = wr;
        await_rdy(lat, dq);
        check({tag, " latency"}, lat, 2);
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " rdy width"}, rdy, 1'b0);
    endtask

    // Hold a read for 8 completions on one of the extra instances and check spacing.
    task automatic burst(input string tag, input bit sel_b, input int l);
        int rises[8];
        int n = 0;
        int k = 0;
        for (int i = 0; i < 8; i++) rises[i] = 0;
        @(negedge clk);
        addr = 24'h000012;
        if (sel_b) read_b = 1'b1; else read_a = 1'b1;
        while (n < 8 && k < 400) begin
            @(posedge clk);
            #1;
            k++;
            if (sel_b ? rdy_b : rdy_a) begin
                rises[n] = k;
                n++;
            end
        end
        @(negedge clk);
        read_a = 1'b0; read_b = 1'b0;
        check({tag, " pulses"}, n, 8);
        check({tag, " first rdy"}, rises[0], l + 1);
        for (int i = 1; i < 8; i++) begin
            check({tag, " spacing"}, rises[i] - rises[i-1], l + 2);
        end
        check({tag, " rd_count"}, sel_b ? rd_count_b : rd_count_a, STATS ? 8 : 0);
        check({tag, " data"}, sel_b ? data_in_b : data_in_a, 8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [7:0] dq;
        int         lat;

        // Reset held with a read pending: nothing may respond.
        rst_n = 1'b0; read = 1'b1; write = 1'b0; addr = 24'h0; data_out = 8'h0;
        read_a = 1'b0; read_b = 1'b0; write_ab = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset rdy", rdy, 1'b0);
            check("reset data_in", data_in, 8'h00);
        end
        check("reset rd_count", rd_count, 16'h0);
        check("reset wr_count", wr_count, 16'h0);

        // Release with read still high: first edge after release samples it.
        @(negedge clk);
        rst_n = 1'b1;
        await_rdy(lat, dq);
        check("post-reset latency", lat, 2);
        check("post-reset data", dq, 8'h00);
        @(negedge clk);
        read = 1'b0;
        @(posedge clk);
        #1;
        check("post-reset rdy width", rdy, 1'b0);

        // Write then read back.
        txn("wr12", 1'b0, 1'b1, 24'h000012, 8'hA5, dq);
        check("write keeps data_in", data_in, 8'h00);
        txn("rd12", 1'b1, 1'b0, 24'h000012, 8'h00, dq);
        check("rd12 data", dq, 8'hA5);

        // Aliasing modulo 1 KiB.
        txn("wr400", 1'b0, 1'b1, 24'h000400, 8'h3C, dq);
        txn("rd000", 1'b1, 1'b0, 24'h000000, 8'h00, dq);
        check("alias data", dq, 8'h3C);
        txn("rd001", 1'b1, 1'b0, 24'h000001, 8'h00, dq);
        check("unwritten data", dq, 8'h00);

        // Read/write collision: read wins, memory untouched.
        txn("wr20", 1'b0, 1'b1, 24'h000020, 8'h11, dq);
        txn("collide", 1'b1, 1'b1, 24'h000020, 8'hFF, dq);
        check("collide data", dq, 8'h11);
        txn("rd20", 1'b1, 1'b0, 24'h000020, 8'h00, dq);
        check("collide no commit", dq, 8'h11);
        check("rd_count before abort", rd_count, STATS ? 16'd6 : 16'd0);
        check("wr_count before abort", wr_count, STATS ? 16'd3 : 16'd0);

        // Reset pulsed while the write sits in WAIT.
        @(negedge clk);
        addr = 24'h000030; data_out = 8'h77; write = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; write = 1'b0;
        #1;
        check("abort rdy", rdy, 1'b0);
        check("abort data_in", data_in, 8'h00);
        check("abort rd_count", rd_count, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("abort no rdy", rdy, 1'b0);
        end
        txn("rd30", 1'b1, 1'b0, 24'h000030, 8'h00, dq);
        check("abort no commit", dq, 8'h00);
        check("rd_count after abort", rd_count, STATS ? 16'd1 : 16'd0);
        check("wr_count after abort", wr_count, 16'd0);

        // Back-to-back throughput at the latency extremes.
        burst("lat1", 1'b0, 1);
        burst("lat15", 1'b1, 15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
